imem_loader: RTL and testbench
==============================

# imem_loader

Byte-stream instruction-memory writer: receives a framed program image from a byte source (UART RX or testbench), assembles little-endian 32-bit words, and drives the write port of the single-cycle core's instruction memory. It holds the core in reset until a complete, checksum-verified image is written, and makes the core's instruction memory loadable at runtime instead of being fixed at elaboration.

## Interface
Parameters:
- DEPTH, 32: instruction memory depth in words; legal word count is 1..DEPTH.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte; a byte transfers when rx_valid && rx_ready.
- restart  in  1  single-cycle pulse; returns the loader from DONE or ERROR to IDLE.
- imem_we  out  1  instruction memory write enable, one cycle per word.
- imem_waddr  out  32  byte address, word aligned (bits [1:0] = 0).
- imem_wdata  out  32  instruction word.
- core_hold  out  1  holds the core in reset while high.
- done  out  1  image loaded and verified.
- error  out  1  frame rejected.

## Operation
The frame is: SYNC_BYTE, count N (8 bits), 4·N data bytes with each word LSB first, then a checksum byte.

The checksum is the XOR of all data bytes. The sync byte and the count byte are not included.

States:
- IDLE: rx_ready=1. Bytes other than SYNC_BYTE are discarded. On SYNC_BYTE, go to COUNT.
- COUNT: rx_ready=1. If N==0 or N>DEPTH, go to ERROR. Otherwise latch N, clear the word index and byte lane, and go to DATA.
- DATA: rx_ready=1.
  - Each accepted byte fills lane 0..3 of the assembly register.
  - On lane 3, the full word is registered to imem_wdata, imem_waddr = index·4, and imem_we is pulsed; then the index increments.
  - After word N−1, go to CHECK.
- CHECK: rx_ready=1. If the accepted byte equals the running XOR, go to DONE; otherwise go to ERROR.
- DONE: rx_ready=0, done=1, core_hold=0.
- ERROR: rx_ready=0, error=1, core_hold=1.

Additional rules:
- restart in DONE or ERROR: go to IDLE and set core_hold=1; done, error and the running XOR are cleared. restart in any other state is ignored.
- Words already written before an ERROR remain in memory. Reloading overwrites them.

## Timing
- Reset values:
  - state = IDLE; rx_ready = 1; core_hold = 1.
  - imem_we = 0; imem_waddr = 0; imem_wdata = 0.
  - done = 0; error = 0.
- Write latency: imem_we is high exactly one cycle, the cycle after the 4th byte of a word is accepted. imem_waddr and imem_wdata are valid in that same cycle.
- Bytes may arrive back-to-back, one per cycle. Throughput is one byte per cycle with no stalls.
- done/error assert the cycle after the checksum (or bad count) byte is accepted. core_hold falls in the same cycle that done rises.
- restart in the same cycle as rx_valid: restart wins. rx_ready is 0 in DONE/ERROR, so no byte is consumed.
- rx_valid low mid-frame: state and lane are held indefinitely. There is no timeout.
- reset_n asserted mid-frame: everything returns to its reset values immediately. A partial word is never written.
- Word index width: $clog2(DEPTH)+1 bits, so no wrap occurs at N == DEPTH.

## Configuration
- IMEM_LOADER_CHKSUM_EN defined: the CHECK state and the XOR accumulator are present, as described above.
- IMEM_LOADER_CHKSUM_EN undefined: the frame has no checksum byte. After the last word's imem_we cycle, go directly to DONE (done rises the cycle after the final write). ERROR is then reachable only through a bad count.

## Structure
- A shared package holds:
  - the loader state enum (IDLE, COUNT, DATA, CHECK, DONE, ERROR);
  - the default SYNC_BYTE constant;
  - the IMEM depth constant, also used by the instruction memory.
- No sub-module is needed. The single FSM with its datapath registers is sufficient.
- The instruction memory gains a synchronous write port (we, waddr, wdata) driven by this block.

## Test plan
- Valid 2-word load: bytes A5 02 93 00 31 00 13 81 D2 FF 1D.
  - Write 1: imem_waddr 0x0, imem_wdata 0x00310093.
  - Write 2: imem_waddr 0x4, imem_wdata 0xFFD28113.
  - Then done=1 and core_hold=0.
- Bad checksum: same frame with last byte 1C. Both writes occur, then error=1 and core_hold=1. After a restart pulse, the state is IDLE and error=0.
- Bad count: bytes A5 00 give error the next cycle with no imem_we. Likewise, A5 21 with DEPTH=32 gives error.
- Garbage before sync: bytes 00 FF 5A, then a valid 1-word frame A5 01 13 00 00 00 13. Exactly one write: addr 0x0, data 0x00000013.
- Gapped stream: the valid 2-word frame with rx_valid low for 3 cycles between every byte. Same writes and result as the first scenario.
- reset_n pulsed after 6 data bytes: no further writes and outputs at reset values. A subsequent full frame loads correctly.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared loader state type and instruction-memory constants
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } loader_state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         IMEM_DEPTH        = 32;

endpackage

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream writer for the core's instruction memory
// Optional trailing XOR checksum byte when IMEM_LOADER_CHKSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         DEPTH     = IMEM_DEPTH,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        restart,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        error
);

  localparam int         IDX_W     = $clog2(DEPTH) + 1;
  localparam logic [8:0] DEPTH_LIM = 9'(DEPTH);

  loader_state_e    state_q, state_d;
  logic [IDX_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       lane_q, lane_d;
  logic [23:0]      asm_q, asm_d;
  logic             we_q, we_d;
  logic [31:0]      waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHKSUM_EN
  logic [7:0]       xor_q, xor_d;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    idx_d    = idx_q;
    lane_d   = lane_q;
    asm_d    = asm_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    rx_ready = 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
    xor_d    = xor_q;
`endif
    case (state_q)
      ST_IDLE: begin
        rx_ready = 1'b1;
        if (rx_valid && rx_data == SYNC_BYTE) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (rx_data == 8'd0 || {1'b0, rx_data} > DEPTH_LIM) begin
            state_d = ST_ERROR;
          end else begin
            count_d = IDX_W'(rx_data);
            idx_d   = '0;
            lane_d  = '0;
`ifdef IMEM_LOADER_CHKSUM_EN
            xor_d   = '0;
`endif
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
`ifndef IMEM_LOADER_CHKSUM_EN
        // idx == count only during the final word's write cycle
        if (idx_q == count_q) begin
          state_d = ST_DONE;
        end else
`endif
        begin
          rx_ready = 1'b1;
          if (rx_valid) begin
`ifdef IMEM_LOADER_CHKSUM_EN
            xor_d = xor_q ^ rx_data;
`endif
            lane_d = lane_q + 2'd1;
            case (lane_q)
              2'd0:    asm_d[7:0]   = rx_data;
              2'd1:    asm_d[15:8]  = rx_data;
              2'd2:    asm_d[23:16] = rx_data;
              default: begin
                we_d    = 1'b1;
                wdata_d = {rx_data, asm_q};
                waddr_d = 32'({idx_q, 2'b00});
                idx_d   = idx_q + IDX_W'(1);
`ifdef IMEM_LOADER_CHKSUM_EN
                if (idx_q == count_q - IDX_W'(1)) state_d = ST_CHECK;
`endif
              end
            endcase
          end
        end
      end
      ST_CHECK: begin
`ifdef IMEM_LOADER_CHKSUM_EN
        rx_ready = 1'b1;
        if (rx_valid) state_d = (rx_data == xor_q) ? ST_DONE : ST_ERROR;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE, ST_ERROR: begin
        if (restart) begin
          state_d = ST_IDLE;
`ifdef IMEM_LOADER_CHKSUM_EN
          xor_d   = '0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
`ifdef IMEM_LOADER_CHKSUM_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CHKSUM_EN
      xor_q   <= xor_d;
`endif
    end
  end

  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign done       = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERROR);
  assign core_hold  = (state_q != ST_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader with a frame-level reference model
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int DEPTH = IMEM_DEPTH;
  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        restart;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        core_hold;
  logic        done;
  logic        error;

  imem_loader #(.DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .restart(restart), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .core_hold(core_hold),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int          cyc = 0;
  int          acc_cyc[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          done_cyc[$];
  int          err_cyc[$];
  logic        done_prev = 1'b0;
  logic        err_prev  = 1'b0;

  always @(posedge clk) begin
    if (rx_valid && rx_ready) acc_cyc.push_back(cyc);
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_waddr);
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(cyc);
    end
    if (done && !done_prev) done_cyc.push_back(cyc);
    if (error && !err_prev) err_cyc.push_back(cyc);
    done_prev <= done;
    err_prev  <= error;
  end

  // Reference model: outcome 0 = frame incomplete, 1 = loaded, 2 = rejected
  logic [31:0] m_addr[$];
  logic [31:0] m_data[$];
  int          m_pos[$];
  int          m_outcome;
  int          m_term_pos;
  int          last_wr_base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input byte_q_t s);
    int p;
    int n;
    int b0;
    logic [7:0] x;
    m_addr.delete();
    m_data.delete();
    m_pos.delete();
    m_outcome  = 0;
    m_term_pos = -1;
    p = -1;
    for (int i = 0; i < s.size(); i++) begin
      if (s[i] == 8'hA5) begin
        p = i;
        break;
      end
    end
    if (p < 0 || p + 1 >= s.size()) return;
    n = int'(s[p+1]);
    if (n == 0 || n > DEPTH) begin
      m_outcome  = 2;
      m_term_pos = p + 1;
      return;
    end
    x = 8'h00;
    for (int w = 0; w < n; w++) begin
      b0 = p + 2 + 4 * w;
      if (b0 + 3 >= s.size()) return;
      m_addr.push_back(32'(4 * w));
      m_data.push_back({s[b0+3], s[b0+2], s[b0+1], s[b0]});
      m_pos.push_back(b0 + 3);
      x = x ^ s[b0] ^ s[b0+1] ^ s[b0+2] ^ s[b0+3];
    end
`ifdef IMEM_LOADER_CHKSUM_EN
    if (p + 2 + 4 * n >= s.size()) return;
    m_term_pos = p + 2 + 4 * n;
    m_outcome  = (s[m_term_pos] == x) ? 1 : 2;
`else
    m_outcome = 1;
`endif
  endtask

  task automatic send_stream(input byte_q_t s, input int gap_max, input bit gap_fixed);
    for (int i = 0; i < s.size(); i++) begin
      @(negedge clk);
      rx_data  = s[i];
      rx_valid = 1'b1;
      @(posedge clk);
      #1 rx_valid = 1'b0;
      repeat (gap_fixed ? gap_max : int'($urandom_range(gap_max, 0))) @(posedge clk);
    end
  endtask

  task automatic run_frame(input string tag, input byte_q_t s, input int gap_max, input bit gap_fixed);
    int acc_base;
    int d_base;
    int e_base;
    int exp_cyc;
    bit acc_ok;
    model(s);
    acc_base     = acc_cyc.size();
    last_wr_base = wr_addr.size();
    d_base       = done_cyc.size();
    e_base       = err_cyc.size();
    send_stream(s, gap_max, gap_fixed);
    repeat (4) @(negedge clk);
    acc_ok = (acc_cyc.size() - acc_base == s.size());
    chk({tag, " accepted"}, acc_cyc.size() - acc_base, s.size());
    chk({tag, " writes"}, wr_addr.size() - last_wr_base, m_addr.size());
    for (int i = 0; i < m_addr.size() && last_wr_base + i < wr_addr.size(); i++) begin
      chk($sformatf("%s waddr[%0d]", tag, i), wr_addr[last_wr_base+i], m_addr[i]);
      chk($sformatf("%s wdata[%0d]", tag, i), wr_data[last_wr_base+i], m_data[i]);
      if (acc_ok)
        chk($sformatf("%s wcyc[%0d]", tag, i), wr_cyc[last_wr_base+i], acc_cyc[acc_base+m_pos[i]] + 1);
    end
    chk({tag, " done"}, 32'(done), 32'(m_outcome == 1));
    chk({tag, " error"}, 32'(error), 32'(m_outcome == 2));
    chk({tag, " core_hold"}, 32'(core_hold), 32'(m_outcome != 1));
    chk({tag, " rx_ready"}, 32'(rx_ready), 32'(m_outcome == 0));
    chk({tag, " done_events"}, done_cyc.size() - d_base, (m_outcome == 1) ? 1 : 0);
    chk({tag, " err_events"}, err_cyc.size() - e_base, (m_outcome == 2) ? 1 : 0);
    if (acc_ok && m_outcome == 1 && done_cyc.size() > d_base) begin
      exp_cyc = (m_term_pos >= 0) ? acc_cyc[acc_base+m_term_pos] + 1
                                  : acc_cyc[acc_base+m_pos[m_pos.size()-1]] + 2;
      chk({tag, " done_cyc"}, done_cyc[d_base], exp_cyc);
    end
    if (acc_ok && m_outcome == 2 && err_cyc.size() > e_base)
      chk({tag, " err_cyc"}, err_cyc[e_base], acc_cyc[acc_base+m_term_pos] + 1);
  endtask

  task automatic restart_pulse(input string tag);
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk);
    #1 restart = 1'b0;
    @(negedge clk);
    chk({tag, " restart done"}, 32'(done), 32'd0);
    chk({tag, " restart error"}, 32'(error), 32'd0);
    chk({tag, " restart core_hold"}, 32'(core_hold), 32'd1);
    chk({tag, " restart rx_ready"}, 32'(rx_ready), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " rx_ready"}, 32'(rx_ready), 32'd1);
    chk({tag, " core_hold"}, 32'(core_hold), 32'd1);
    chk({tag, " imem_we"}, 32'(imem_we), 32'd0);
    chk({tag, " imem_waddr"}, imem_waddr, 32'd0);
    chk({tag, " imem_wdata"}, imem_wdata, 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " error"}, 32'(error), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t s1;
    byte_q_t s;
    int n;
    int wb;
    logic [7:0] b;
    logic [7:0] x;

    reset_n  = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    restart  = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("in_reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("after_reset");

    s1 = '{8'hA5, 8'h02, 8'h93, 8'h00, 8'h31, 8'h00, 8'h13, 8'h81, 8'hD2, 8'hFF};
`ifdef IMEM_LOADER_CHKSUM_EN
    s1.push_back(8'h1D);
`endif
    run_frame("load2", s1, 0, 1'b1);
    if (wr_data.size() >= last_wr_base + 2) begin
      chk("load2 word0 const", wr_data[last_wr_base], 32'h00310093);
      chk("load2 word1 const", wr_data[last_wr_base+1], 32'hFFD28113);
      chk("load2 addr1 const", wr_addr[last_wr_base+1], 32'h4);
    end else begin
      chk("load2 write count const", wr_data.size() - last_wr_base, 2);
    end
    restart_pulse("load2");

`ifdef IMEM_LOADER_CHKSUM_EN
    s = s1;
    s[s.size()-1] = 8'h1C;
    run_frame("badsum", s, 0, 1'b1);
    restart_pulse("badsum");
`endif

    run_frame("cnt0", '{8'hA5, 8'h00}, 0, 1'b1);
    restart_pulse("cnt0");
    run_frame("cnt_over", '{8'hA5, 8'(DEPTH + 1)}, 0, 1'b1);
    restart_pulse("cnt_over");

    s = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHKSUM_EN
    s.push_back(8'h13);
`endif
    run_frame("garbage", s, 0, 1'b1);
    chk("garbage wdata const", (wr_data.size() > last_wr_base) ? wr_data[last_wr_base] : 32'hDEAD, 32'h00000013);
    restart_pulse("garbage");

    run_frame("gapped", s1, 3, 1'b1);
    restart_pulse("gapped");

    s = '{8'hA5, 8'h02, 8'h93, 8'h00, 8'h31, 8'h00, 8'h13, 8'h81};
    run_frame("partial", s, 0, 1'b1);
    wb = wr_addr.size();
    @(negedge clk);
    reset_n = 1'b0;
    #1 check_reset_values("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midreset no_write", wr_addr.size() - wb, 0);
    check_reset_values("midreset_after");
    run_frame("reload", s1, 0, 1'b1);
    restart_pulse("reload");

    for (int k = 0; k < 8; k++) begin
      s.delete();
      n = (k == 0) ? DEPTH : (k == 1) ? 1 : int'($urandom_range(DEPTH, 1));
      repeat ($urandom_range(3, 0)) begin
        b = 8'($urandom);
        s.push_back((b == 8'hA5) ? 8'h00 : b);
      end
      s.push_back(8'hA5);
      s.push_back(8'(n));
      x = 8'h00;
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        x = x ^ b;
        s.push_back(b);
      end
`ifdef IMEM_LOADER_CHKSUM_EN
      if ($urandom_range(2, 0) == 0) x = x ^ (8'h01 << $urandom_range(7, 0));
      s.push_back(x);
`endif
      run_frame($sformatf("rand%0d", k), s, 2, 1'b0);
      if (done || error) restart_pulse($sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
